// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: control word layout, ALU op encoding, opcodes.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ADD   = 2'b00,
        BR    = 2'b01,
        RTYPE = 2'b10
    } alu_op_t;

    // Field order fixes the bit layout: alu_src is the MSB, alu_op the two LSBs.
    typedef struct packed {
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        alu_op_t alu_op;
    } ctrl_t;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that needs the result
// of the load currently in EX, which is not available until after MEM.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_alu_src,
    input  logic                  id_mem_write,
    output logic                  lu
);

    logic rs1_hit;
    logic rs2_hit;

    // rs2 only matters when it is really read: R-type/branch (alu_src=0) or store data.
    // A load to x0 never produces a value, so it can never cause a hazard.
    always_comb begin
        rs1_hit = (ex_rd == id_rs1);
        rs2_hit = (ex_rd == id_rs2) & (~id_alu_src | id_mem_write);
        lu      = ex_valid & ex_mem_read & id_valid & (ex_rd != '0) & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the RV64 core. Captures the decode slot, inserts
// bubbles on flush (and on load-use hazards), and requests an upstream stall.
// Build option: define ID_EX_HAZARD_EN to enable load-use detection; without it
// the core relies on the compiler to schedule around load-use hazards.
module id_ex_pipe_reg
    import riscv_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_funct,
    input  ctrl_t                 id_ctrl,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [3:0]            ex_funct,
    output ctrl_t                 ex_ctrl,
    output logic                  stall_up
);

    logic clear;

`ifdef ID_EX_HAZARD_EN
    logic lu;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_rd        (ex_rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_alu_src   (id_ctrl.alu_src),
        .id_mem_write (id_ctrl.mem_write),
        .lu           (lu)
    );

    // A hazard bubble only loads when hold is not freezing the register.
    always_comb begin
        clear    = reset | flush | (~hold & lu);
        stall_up = ~reset & ~flush & (hold | lu);
    end
`else
    // Without hazard detection only reset and flush empty the EX slot.
    always_comb begin
        clear    = reset | flush;
        stall_up = ~reset & ~flush & hold;
    end
`endif

    // Priority reset > flush > hold > bubble > capture; a bubble is an all-zero slot.
    always_ff @(posedge clk) begin
        if (clear) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_ctrl     <= '0;
        end else if (!hold) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg. Expectations follow the build option
// ID_EX_HAZARD_EN (load-use stalls only exist when it is defined).
module tb_id_ex_pipe_reg;
    import riscv_pkg::*;

`ifdef ID_EX_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam ctrl_t C_RTYPE = '{alu_src:1'b0, mem_to_reg:1'b0, reg_write:1'b1, mem_read:1'b0,
                                  mem_write:1'b0, branch:1'b0, alu_op:RTYPE};
    localparam ctrl_t C_LOAD  = '{alu_src:1'b1, mem_to_reg:1'b1, reg_write:1'b1, mem_read:1'b1,
                                  mem_write:1'b0, branch:1'b0, alu_op:ADD};
    localparam ctrl_t C_ADDI  = '{alu_src:1'b1, mem_to_reg:1'b0, reg_write:1'b1, mem_read:1'b0,
                                  mem_write:1'b0, branch:1'b0, alu_op:ADD};
    localparam ctrl_t C_STORE = '{alu_src:1'b1, mem_to_reg:1'b0, reg_write:1'b0, mem_read:1'b0,
                                  mem_write:1'b1, branch:1'b0, alu_op:ADD};

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    ctrl_t       id_ctrl;
    logic        flush, hold;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    ctrl_t       ex_ctrl;
    logic        stall_up;

    int compared   = 0;
    int mismatched = 0;

    id_ex_pipe_reg dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_imm      (id_imm),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_funct    (id_funct),
        .id_ctrl     (id_ctrl),
        .flush       (flush),
        .hold        (hold),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct    (ex_funct),
        .ex_ctrl     (ex_ctrl),
        .stall_up    (stall_up)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                                  input logic [3:0] funct, input ctrl_t ctrl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc ^ 64'h1111_2222_3333_4444;
        id_rs2_data = pc ^ 64'h5555_6666_7777_8888;
        id_imm      = imm;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_funct    = funct;
        id_ctrl     = ctrl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with random decode inputs and hold asserted; stall_up must stay low
        reset = 1'b1; flush = 1'b0; hold = 1'b1;
        apply_stimulus(1'b1, {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom),
                       {$urandom, $urandom}, 4'($urandom), ctrl_t'(8'($urandom)));
        step();
        check_output("rst1_valid", 64'(ex_valid), 64'd0);
        check_output("rst1_stall", 64'(stall_up), 64'd0);
        apply_stimulus(1'b1, {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom),
                       {$urandom, $urandom}, 4'($urandom), ctrl_t'(8'($urandom)));
        step();
        check_output("rst2_valid", 64'(ex_valid), 64'd0);
        check_output("rst2_pc",    ex_pc,         64'd0);
        check_output("rst2_rs1d",  ex_rs1_data,   64'd0);
        check_output("rst2_imm",   ex_imm,        64'd0);
        check_output("rst2_rd",    64'(ex_rd),    64'd0);
        check_output("rst2_funct", 64'(ex_funct), 64'd0);
        check_output("rst2_ctrl",  64'(ex_ctrl),  64'd0);
        check_output("rst2_stall", 64'(stall_up), 64'd0);
        reset = 1'b0; hold = 1'b0;

        // 2: add x3,x1,x2
        apply_stimulus(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 64'd0, 4'b0000, C_RTYPE);
        check_output("add_stall_pre", 64'(stall_up), 64'd0);
        step();
        check_output("add_valid", 64'(ex_valid), 64'd1);
        check_output("add_rd",    64'(ex_rd), 64'd3);
        check_output("add_regw",  64'(ex_ctrl.reg_write), 64'd1);
        check_output("add_ctrl",  64'(ex_ctrl), 64'h22);
        check_output("add_pc",    ex_pc, 64'h100);
        check_output("add_rs1d",  ex_rs1_data, 64'h1111_2222_3333_4544);
        check_output("add_rs2d",  ex_rs2_data, 64'h5555_6666_7777_8988);

        // invalid slot: data captured, control zeroed
        apply_stimulus(1'b0, 64'h104, 5'd4, 5'd5, 5'd9, 64'h7, 4'b1000, C_RTYPE);
        step();
        check_output("inv_valid", 64'(ex_valid), 64'd0);
        check_output("inv_ctrl",  64'(ex_ctrl), 64'd0);
        check_output("inv_rd",    64'(ex_rd), 64'd9);
        check_output("inv_funct", 64'(ex_funct), 64'h8);

        // 3: ld x5,0(x1) then add x6,x5,x7
        apply_stimulus(1'b1, 64'h200, 5'd1, 5'd0, 5'd5, 64'd0, 4'b0011, C_LOAD);
        step();
        check_output("ld_ctrl", 64'(ex_ctrl), 64'hF0);
        apply_stimulus(1'b1, 64'h204, 5'd5, 5'd7, 5'd6, 64'd0, 4'b0000, C_RTYPE);
        check_output("lu_stall", 64'(stall_up), 64'(HZ));
        step();
        check_output("lu_b_valid", 64'(ex_valid), 64'(!HZ));
        check_output("lu_b_pc",    ex_pc, HZ ? 64'd0 : 64'h204);
        check_output("lu_b_ctrl",  64'(ex_ctrl), HZ ? 64'd0 : 64'h22);
        check_output("lu_stall_drop", 64'(stall_up), 64'd0);
        step();
        check_output("lu_cap_valid", 64'(ex_valid), 64'd1);
        check_output("lu_cap_pc",    ex_pc, 64'h204);
        check_output("lu_cap_rd",    64'(ex_rd), 64'd6);

        // rs2 hazard for R-type and for store data
        apply_stimulus(1'b1, 64'h208, 5'd1, 5'd0, 5'd5, 64'd0, 4'b0011, C_LOAD);
        step();
        apply_stimulus(1'b1, 64'h20C, 5'd7, 5'd5, 5'd6, 64'd0, 4'b0000, C_RTYPE);
        check_output("lu_rs2_rtype", 64'(stall_up), 64'(HZ));
        apply_stimulus(1'b1, 64'h20C, 5'd2, 5'd5, 5'd8, 64'h10, 4'b0011, C_STORE);
        check_output("lu_rs2_store", 64'(stall_up), 64'(HZ));

        // 4: addi x6,x0,imm with rs2 field 5 -> no hazard
        apply_stimulus(1'b1, 64'h20C, 5'd0, 5'd5, 5'd6, 64'h5, 4'b0000, C_ADDI);
        check_output("addi_nostall", 64'(stall_up), 64'd0);
        step();
        check_output("addi_valid", 64'(ex_valid), 64'd1);
        check_output("addi_imm",   ex_imm, 64'h5);

        // 5: ld x0 then add x1,x0,x0 -> no hazard
        apply_stimulus(1'b1, 64'h210, 5'd2, 5'd0, 5'd0, 64'd0, 4'b0011, C_LOAD);
        step();
        apply_stimulus(1'b1, 64'h214, 5'd0, 5'd0, 5'd1, 64'd0, 4'b0000, C_RTYPE);
        check_output("x0_nostall", 64'(stall_up), 64'd0);
        step();
        check_output("x0_pc", ex_pc, 64'h214);

        // 6: flush with hold and load-use together
        apply_stimulus(1'b1, 64'h218, 5'd1, 5'd0, 5'd5, 64'd0, 4'b0011, C_LOAD);
        step();
        apply_stimulus(1'b1, 64'h21C, 5'd5, 5'd7, 5'd6, 64'd0, 4'b0000, C_RTYPE);
        flush = 1'b1; hold = 1'b1; #1;
        check_output("flush_stall", 64'(stall_up), 64'd0);
        step();
        check_output("flush_valid", 64'(ex_valid), 64'd0);
        check_output("flush_ctrl",  64'(ex_ctrl), 64'd0);
        check_output("flush_pc",    ex_pc, 64'd0);
        flush = 1'b0; hold = 1'b0;

        // hold for 3 cycles keeps captured slot
        apply_stimulus(1'b1, 64'h300, 5'd3, 5'd4, 5'd10, 64'h40, 4'b0101, C_ADDI);
        step();
        hold = 1'b1;
        apply_stimulus(1'b1, 64'h304, 5'd8, 5'd9, 5'd11, 64'h80, 4'b0001, C_RTYPE);
        for (int i = 0; i < 3; i++) begin
            check_output("hold_stall", 64'(stall_up), 64'd1);
            step();
            check_output("hold_pc",   ex_pc, 64'h300);
            check_output("hold_rd",   64'(ex_rd), 64'd10);
            check_output("hold_ctrl", 64'(ex_ctrl), 64'hA0);
        end
        hold = 1'b0; #1;
        check_output("unhold_stall", 64'(stall_up), 64'd0);
        step();
        check_output("unhold_pc", ex_pc, 64'h304);

        // reset mid-stream discards the slot, stall suppressed even with hold
        reset = 1'b1; hold = 1'b1; #1;
        check_output("mrst_stall", 64'(stall_up), 64'd0);
        step();
        check_output("mrst_valid", 64'(ex_valid), 64'd0);
        check_output("mrst_pc",    ex_pc, 64'd0);
        reset = 1'b0; hold = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
